// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory port arbiter:
// arbiter FSM state encoding and pending-operation encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2,
        ST_WAIT  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/mem_arb_req_slot.sv
// One requester's pending-request register. It captures op/addr/wdata
// on a strobe, holds them until the arbiter signals completion, and
// raises a sticky error when a strobe arrives while a request is
// already outstanding. A strobe in the completion cycle starts a new
// request.
module mem_arb_req_slot
    import mem_arb_pkg::*;
#(
    parameter int AW = 20,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          clear,
    output logic          pending,
    output op_t           op,
    output logic [AW-1:0] addr_q,
    output logic [DW-1:0] wdata_q,
    output logic          err
);

    logic strobe;
    logic can_accept;

    assign strobe     = rd | wr;
    assign can_accept = ~pending | clear;

    // Capture a new request (write wins over read) or flag a strobe that collides with an outstanding one
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            op      <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            err     <= 1'b0;
        end else begin
            if (clear) begin
                pending <= 1'b0;
            end
            if (strobe && can_accept) begin
                pending <= 1'b1;
                op      <= wr ? OP_WRITE : OP_READ;
                addr_q  <= addr;
                wdata_q <= wdata;
            end else if (strobe) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single MappedSPIRAM-style slave.
// Each requester owns a pending slot; the FSM grants one slot in IDLE,
// pulses s_rd/s_wr in ISSUE, spends one GUARD cycle so a late-rising
// slave busy is still seen, then waits in WAIT for busy to drop.
// Build option MEM_ARB_ROUND_ROBIN_EN: when defined, contention is
// resolved by a last-grant bit (m0 first after reset); otherwise m0
// always wins contention.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 20,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_rd,
    input  logic          m0_wr,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_busy,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_rd,
    input  logic          m1_wr,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_busy,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    output logic          s_rd,
    output logic          s_wr,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_rbusy,
    input  logic          s_wbusy,
    output logic          err
);

    arb_state_t    state;
    arb_state_t    state_nxt;

    logic          p0_pending, p1_pending;
    op_t           p0_op, p1_op;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_err, p1_err;

    logic          grant;
    op_t           cur_op;
    logic          pick_m1;
    logic          slave_idle;
    logic          done;
    logic          take_grant;

    assign slave_idle = (cur_op == OP_READ) ? ~s_rbusy : ~s_wbusy;
    assign done       = (state == ST_WAIT) && slave_idle;
    assign take_grant = (state == ST_IDLE) && (p0_pending || p1_pending);

    assign m0_busy = p0_pending;
    assign m1_busy = p1_pending;
    assign err     = p0_err | p1_err;

    mem_arb_req_slot #(.AW(AW), .DW(DW)) u_slot0 (
        .clk     (clk),
        .rst     (rst),
        .rd      (m0_rd),
        .wr      (m0_wr),
        .addr    (m0_addr),
        .wdata   (m0_wdata),
        .clear   (done && !grant),
        .pending (p0_pending),
        .op      (p0_op),
        .addr_q  (p0_addr),
        .wdata_q (p0_wdata),
        .err     (p0_err)
    );

    mem_arb_req_slot #(.AW(AW), .DW(DW)) u_slot1 (
        .clk     (clk),
        .rst     (rst),
        .rd      (m1_rd),
        .wr      (m1_wr),
        .addr    (m1_addr),
        .wdata   (m1_wdata),
        .clear   (done && grant),
        .pending (p1_pending),
        .op      (p1_op),
        .addr_q  (p1_addr),
        .wdata_q (p1_wdata),
        .err     (p1_err)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // Choose a requester; on contention the one not favoured last time wins
    always_comb begin
        pick_m1 = p1_pending && !p0_pending;
        if (p0_pending && p1_pending) begin
            pick_m1 = ~last_grant;
        end
    end

    // Remember who won the most recent contention; reset value makes m0 win first
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (take_grant && p0_pending && p1_pending) begin
            last_grant <= pick_m1;
        end
    end
`else
    // Choose a requester; m0 has fixed priority on contention
    always_comb begin
        pick_m1 = p1_pending && !p0_pending;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the one-cycle slave strobes issued in ISSUE
    always_comb begin
        state_nxt = state;
        s_rd      = 1'b0;
        s_wr      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (p0_pending || p1_pending) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_GUARD;
                s_rd      = (cur_op == OP_READ);
                s_wr      = (cur_op == OP_WRITE);
            end
            ST_GUARD: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (slave_idle) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the grant and slave request in IDLE; capture read data on read completion
    always_ff @(posedge clk) begin
        if (rst) begin
            grant    <= 1'b0;
            cur_op   <= OP_READ;
            s_addr   <= '0;
            s_wdata  <= '0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            if (take_grant) begin
                grant   <= pick_m1;
                cur_op  <= pick_m1 ? p1_op    : p0_op;
                s_addr  <= pick_m1 ? p1_addr  : p0_addr;
                s_wdata <= pick_m1 ? p1_wdata : p0_wdata;
            end
            if (done && cur_op == OP_READ) begin
                if (grant) begin
                    m1_rdata <= s_rdata;
                end else begin
                    m0_rdata <= s_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small
// behavioural slave whose busy delay/length is set per test.
module tb_mem_port_arbiter;

    localparam int AW = 20;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_rd, m0_wr, m1_rd, m1_wr;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_busy, m1_busy;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_rd, s_wr;
    logic [DW-1:0] s_rdata;
    logic          s_rbusy, s_wbusy;
    logic          err;

    int checks = 0;
    int errors = 0;

    int            slave_delay = 0;
    int            slave_len   = 2;
    logic [DW-1:0] slave_rdata = '0;
    int            txn_count   = 0;
    int            rd_count    = 0;
    logic          last_was_wr = 1'b0;
    logic [DW-1:0] last_wdata  = '0;
    logic [AW-1:0] txn_addr [0:31];

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_rd    (m0_rd),
        .m0_wr    (m0_wr),
        .m0_rdata (m0_rdata),
        .m0_busy  (m0_busy),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_rd    (m1_rd),
        .m1_wr    (m1_wr),
        .m1_rdata (m1_rdata),
        .m1_busy  (m1_busy),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_rd     (s_rd),
        .s_wr     (s_wr),
        .s_rdata  (s_rdata),
        .s_rbusy  (s_rbusy),
        .s_wbusy  (s_wbusy),
        .err      (err)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural slave: records each request and raises busy after a configurable delay
    initial begin
        s_rbusy = 1'b0;
        s_wbusy = 1'b0;
        s_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (s_rd || s_wr) begin
                if (txn_count < 32) txn_addr[txn_count] = s_addr;
                txn_count   = txn_count + 1;
                last_was_wr = s_wr;
                last_wdata  = s_wdata;
                if (s_rd) rd_count = rd_count + 1;
                s_rdata = slave_rdata;
                repeat (slave_delay) begin
                    @(posedge clk);
                    #2;
                end
                if (last_was_wr) s_wbusy = 1'b1;
                else             s_rbusy = 1'b1;
                repeat (slave_len) begin
                    @(posedge clk);
                    #2;
                end
                s_rbusy = 1'b0;
                s_wbusy = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of strobes, then release them just after the capturing edge
    task automatic applyStimulus(input logic rd0, input logic wr0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic rd1, input logic wr1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        m0_rd = rd0; m0_wr = wr0; m0_addr = a0; m0_wdata = d0;
        m1_rd = rd1; m1_wr = wr1; m1_addr = a1; m1_wdata = d1;
        @(posedge clk);
        #1;
        m0_rd = 1'b0; m0_wr = 1'b0; m1_rd = 1'b0; m1_wr = 1'b0;
    endtask

    // Count cycles until both requesters are idle, bounded
    task automatic waitIdle(output int cycles);
        cycles = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            cycles = k;
            if (!m0_busy && !m1_busy) break;
        end
        checkOutput("idle", {62'd0, m0_busy, m1_busy}, 64'd0);
    endtask

    int cyc;
    int base;
    int base_rd;
    logic m0_first;

    initial begin
        rst = 1'b1;
        m0_rd = 1'b0; m0_wr = 1'b0; m1_rd = 1'b0; m1_wr = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_m0_busy", m0_busy, 0);
        checkOutput("rst_m1_busy", m1_busy, 0);
        checkOutput("rst_s_rd", s_rd, 0);
        checkOutput("rst_s_wr", s_wr, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_s_addr", s_addr, 0);
        checkOutput("rst_m0_rdata", m0_rdata, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic read, busy rises with s_rd and lasts 5 cycles
        slave_delay = 0; slave_len = 5; slave_rdata = 32'hDEADBEEF;
        base = txn_count;
        applyStimulus(1, 0, 20'h00010, 0, 0, 0, 0, 0);
        checkOutput("rd_busy_rise", m0_busy, 1);
        waitIdle(cyc);
        checkOutput("rd_latency", cyc, 7);
        checkOutput("rd_txn_count", txn_count - base, 1);
        checkOutput("rd_s_addr", txn_addr[base], 20'h00010);
        checkOutput("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
        checkOutput("rd_m1_rdata", m1_rdata, 0);

        // Slave busy one cycle after s_rd
        slave_delay = 1; slave_len = 5; slave_rdata = 32'hCAFEF00D;
        base = txn_count;
        applyStimulus(1, 0, 20'h00020, 0, 0, 0, 0, 0);
        waitIdle(cyc);
        checkOutput("late1_latency", cyc, 8);
        checkOutput("late1_txn_count", txn_count - base, 1);
        checkOutput("late1_m0_rdata", m0_rdata, 32'hCAFEF00D);

        // Slave busy two cycles after s_rd: still caught thanks to GUARD
        slave_delay = 2; slave_len = 5; slave_rdata = 32'h0BADF00D;
        base = txn_count;
        applyStimulus(1, 0, 20'h00024, 0, 0, 0, 0, 0);
        waitIdle(cyc);
        checkOutput("late2_latency", cyc, 9);
        checkOutput("late2_m0_rdata", m0_rdata, 32'h0BADF00D);

        // Simultaneous rd and wr from m0: write wins, rdata untouched
        slave_delay = 0; slave_len = 2; slave_rdata = 32'h55555555;
        base = txn_count; base_rd = rd_count;
        applyStimulus(1, 1, 20'h00030, 32'h12345678, 0, 0, 0, 0);
        waitIdle(cyc);
        checkOutput("rw_txn_count", txn_count - base, 1);
        checkOutput("rw_is_write", last_was_wr, 1);
        checkOutput("rw_wdata", last_wdata, 32'h12345678);
        checkOutput("rw_no_read", rd_count - base_rd, 0);
        checkOutput("rw_m0_rdata", m0_rdata, 32'h0BADF00D);

        // Double strobe from m1 while pending
        slave_delay = 0; slave_len = 3; slave_rdata = 32'h11112222;
        base = txn_count;
        checkOutput("dbl_err_before", err, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 20'h00040, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 20'h00044, 0);
        checkOutput("dbl_err", err, 1);
        waitIdle(cyc);
        checkOutput("dbl_txn_count", txn_count - base, 1);
        checkOutput("dbl_s_addr", txn_addr[base], 20'h00040);
        checkOutput("dbl_m1_rdata", m1_rdata, 32'h11112222);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("dbl_no_extra", txn_count - base, 1);
        checkOutput("dbl_err_sticky", err, 1);

        // Reset while waiting on the slave
        slave_delay = 0; slave_len = 10; slave_rdata = 32'h99999999;
        base = txn_count;
        applyStimulus(1, 0, 20'h00050, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("wait_busy", m0_busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rstw_busy", m0_busy, 0);
        checkOutput("rstw_s_rd", s_rd, 0);
        checkOutput("rstw_s_wr", s_wr, 0);
        checkOutput("rstw_err", err, 0);
        checkOutput("rstw_s_addr", s_addr, 0);
        checkOutput("rstw_m0_rdata", m0_rdata, 0);
        for (int k = 0; k < 100 && (s_rbusy || s_wbusy); k++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstw_txn_count", txn_count - base, 1);
        checkOutput("rstw_m0_rdata_after", m0_rdata, 0);
        checkOutput("rstw_busy_after", m0_busy, 0);

        // Repeated contention: m0 write vs m1 read in the same cycle
        slave_delay = 0; slave_len = 2; slave_rdata = 32'hABCD0000;
        for (int r = 0; r < 3; r++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            m0_first = (r % 2 == 0);
`else
            m0_first = 1'b1;
`endif
            base = txn_count;
            slave_rdata = 32'hABCD0000 + r;
            applyStimulus(0, 1, 20'h00100 + r, 32'hA0A00000 + r, 1, 0, 20'h00200 + r, 0);
            checkOutput("ctn_both_busy", {62'd0, m0_busy, m1_busy}, 64'd3);
            waitIdle(cyc);
            checkOutput("ctn_txn_count", txn_count - base, 2);
            checkOutput("ctn_first", txn_addr[base], m0_first ? 20'h00100 + r : 20'h00200 + r);
            checkOutput("ctn_second", txn_addr[base + 1], m0_first ? 20'h00200 + r : 20'h00100 + r);
            checkOutput("ctn_m1_rdata", m1_rdata, 32'hABCD0000 + r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
